// File: rtl/wb_stage_pipelined_pkg.sv
// Shared encodings for the write-back stage: result-select codes, load-size
// codes and the default link increment.
package wb_stage_pipelined_pkg;

  typedef enum logic [1:0] {
    REG_IN_PC4   = 2'b00,
    REG_IN_DOUT  = 2'b01,
    REG_IN_ALU   = 2'b10,
    REG_IN_IMM16 = 2'b11
  } reg_in_sel_e;

  localparam logic [1:0] LD_BYTE = 2'b00;
  localparam logic [1:0] LD_HALF = 2'b01;
  localparam logic [1:0] LD_WORD = 2'b10;

  localparam int PC_INC_DEFAULT = 4;

endpackage

// File: rtl/wb_stage_pipelined_if.sv
// MEM/WB handshake bundle plus the register-file write and forwarding bus.
// The master side is the MEM stage / register file, the slave side is the stage.
interface wb_stage_pipelined_if #(
  parameter int DBITS               = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int CNT_BITS            = 16
);
  logic                           in_valid;
  logic                           in_ready;
  logic                           flush;
  logic                           rf_ready;
  logic [REG_INDEX_BIT_WIDTH-1:0] dest_reg_addr;
  logic                           wr_reg_in;
  logic [1:0]                     sel_reg_din;
  logic [1:0]                     ld_size;
  logic                           ld_signed;
  logic [1:0]                     byte_off;
  logic [DBITS-1:0]               imm16;
  logic [DBITS-1:0]               alu_out;
  logic [DBITS-1:0]               data_out;
  logic [DBITS-1:0]               pc;

  logic                           wr_reg;
  logic [REG_INDEX_BIT_WIDTH-1:0] reg_addr;
  logic [DBITS-1:0]               reg_din;
  logic                           fwd_valid;
  logic [REG_INDEX_BIT_WIDTH-1:0] fwd_addr;
  logic [DBITS-1:0]               fwd_data;
  logic                           misalign;
  logic [CNT_BITS-1:0]            retired_count;

  modport master (
    output in_valid, flush, rf_ready, dest_reg_addr, wr_reg_in, sel_reg_din,
           ld_size, ld_signed, byte_off, imm16, alu_out, data_out, pc,
    input  in_ready, wr_reg, reg_addr, reg_din, fwd_valid, fwd_addr, fwd_data,
           misalign, retired_count
  );

  modport slave (
    input  in_valid, flush, rf_ready, dest_reg_addr, wr_reg_in, sel_reg_din,
           ld_size, ld_signed, byte_off, imm16, alu_out, data_out, pc,
    output in_ready, wr_reg, reg_addr, reg_din, fwd_valid, fwd_addr, fwd_data,
           misalign, retired_count
  );
endinterface

// File: rtl/wb_stage_pipelined_load_align.sv
// Combinational load aligner: picks the addressed byte/half/word out of the
// memory word, extends it, and reports an unaligned access.
module wb_load_align
  import wb_stage_pipelined_pkg::*;
#(
  parameter int DBITS = 32
) (
  input  logic [DBITS-1:0] data_out,
  input  logic [1:0]       ld_size,
  input  logic             ld_signed,
  input  logic [1:0]       byte_off,
  output logic [DBITS-1:0] aligned,
  output logic             misalign
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    byte_val = data_out[{byte_off, 3'b000} +: 8];
    half_val = data_out[{byte_off[1], 4'b0000} +: 16];
    aligned  = data_out;
    misalign = 1'b0;
    case (ld_size)
      LD_BYTE: aligned = {{(DBITS-8){ld_signed & byte_val[7]}}, byte_val};
      LD_HALF: begin
        aligned  = {{(DBITS-16){ld_signed & half_val[15]}}, half_val};
        misalign = byte_off[0];
      end
      // Word and the reserved encoding both take the full bus unchanged.
      default: misalign = (byte_off != 2'b00);
    endcase
  end

endmodule

// File: rtl/wb_stage_pipelined.sv
// Registered write-back stage: latches one MEM/WB entry, selects and aligns
// the result, and drives the register-file write, forwarding and retire count.
module wb_stage_pipelined
  import wb_stage_pipelined_pkg::*;
#(
  parameter int DBITS               = 32,
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int PC_INC              = PC_INC_DEFAULT,
  parameter bit R0_HARDWIRED        = 1'b0,
  parameter int CNT_BITS            = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  wb_stage_pipelined_if.slave  bus
);

  logic                           held_valid_q, held_valid_d;
  logic                           held_wr_q, held_wr_d;
  logic                           held_mis_q, held_mis_d;
  logic [REG_INDEX_BIT_WIDTH-1:0] held_addr_q, held_addr_d;
  logic [DBITS-1:0]               held_data_q, held_data_d;
  logic [CNT_BITS-1:0]            count_q, count_d;

  logic             in_ready;
  logic             accept;
  logic             commit;
  logic             wr_en;
  logic [DBITS-1:0] load_data;
  logic             load_mis;
  logic [DBITS-1:0] result;
  logic             result_mis;

  wb_load_align #(.DBITS(DBITS)) u_load_align (
    .data_out  (bus.data_out),
    .ld_size   (bus.ld_size),
    .ld_signed (bus.ld_signed),
    .byte_off  (bus.byte_off),
    .aligned   (load_data),
    .misalign  (load_mis)
  );

  always_comb begin
    in_ready = (!held_valid_q || bus.rf_ready) && !bus.flush;
    accept   = bus.in_valid && in_ready;
    commit   = held_valid_q && bus.rf_ready && !bus.flush;

    result     = bus.alu_out;
    result_mis = 1'b0;
    case (reg_in_sel_e'(bus.sel_reg_din))
      REG_IN_PC4:   result = bus.pc + DBITS'(PC_INC);
      REG_IN_DOUT: begin
        result     = load_data;
        // Only a load that actually writes back can be flagged misaligned.
        result_mis = load_mis && bus.wr_reg_in;
      end
      REG_IN_ALU:   result = bus.alu_out;
      REG_IN_IMM16: result = bus.imm16;
      default:      result = bus.alu_out;
    endcase

    held_valid_d = held_valid_q;
    held_wr_d    = held_wr_q;
    held_mis_d   = held_mis_q;
    held_addr_d  = held_addr_q;
    held_data_d  = held_data_q;
    if (bus.flush) begin
      held_valid_d = 1'b0;
    end else if (accept) begin
      held_valid_d = 1'b1;
      held_wr_d    = bus.wr_reg_in;
      held_mis_d   = result_mis;
      held_addr_d  = bus.dest_reg_addr;
      held_data_d  = result;
    end else if (commit) begin
      held_valid_d = 1'b0;
    end

    count_d = commit ? count_q + CNT_BITS'(1) : count_q;

    wr_en = held_valid_q && held_wr_q && !held_mis_q && !bus.flush;
    if (R0_HARDWIRED && (held_addr_q == '0)) wr_en = 1'b0;
  end

  // NOTE: the held data and address are reset too (not just the valid bit)
  // because reg_din/reg_addr are visible straight from these flops.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_valid_q <= 1'b0;
      held_wr_q    <= 1'b0;
      held_mis_q   <= 1'b0;
      held_addr_q  <= '0;
      held_data_q  <= '0;
      count_q      <= '0;
    end else begin
      held_valid_q <= held_valid_d;
      held_wr_q    <= held_wr_d;
      held_mis_q   <= held_mis_d;
      held_addr_q  <= held_addr_d;
      held_data_q  <= held_data_d;
      count_q      <= count_d;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.wr_reg        = wr_en;
  assign bus.reg_addr      = held_addr_q;
  assign bus.reg_din       = held_data_q;
  assign bus.fwd_valid     = wr_en;
  assign bus.fwd_addr      = held_addr_q;
  assign bus.fwd_data      = held_data_q;
  assign bus.misalign      = held_valid_q && held_mis_q;
  assign bus.retired_count = count_q;

endmodule

// File: tb/tb_wb_stage_pipelined.sv
// Directed bench for wb_stage_pipelined: reset, result select, load alignment,
// misalignment, back-pressure, flush, PC wrap and asynchronous reset mid-stall.
module tb_wb_stage_pipelined;
  import wb_stage_pipelined_pkg::*;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;

  wb_stage_pipelined_if #(.DBITS(32), .REG_INDEX_BIT_WIDTH(4), .CNT_BITS(16)) bus ();

  wb_stage_pipelined #(
    .DBITS(32), .REG_INDEX_BIT_WIDTH(4), .PC_INC(4), .R0_HARDWIRED(1'b0), .CNT_BITS(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic [1:0] sel, input logic [3:0] dest,
                       input logic wr, input logic [1:0] size, input logic sgn,
                       input logic [1:0] off, input logic [31:0] val);
    bus.in_valid      = valid;
    bus.sel_reg_din   = sel;
    bus.dest_reg_addr = dest;
    bus.wr_reg_in     = wr;
    bus.ld_size       = size;
    bus.ld_signed     = sgn;
    bus.byte_off      = off;
    bus.imm16         = val;
    bus.alu_out       = val;
    bus.data_out      = val;
    bus.pc            = val;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.rf_ready = 1'b1;
    drive(1'b0, REG_IN_ALU, 4'd0, 1'b0, LD_WORD, 1'b0, 2'd0, 32'h0);
    repeat (2) step();
    reset = 1'b1;
    #1;
    vec_cnt++;
    if ({bus.wr_reg, bus.fwd_valid, bus.misalign} !== 3'b000) begin
      err_cnt++; $display("FAIL reset_flags: got %b required 000", {bus.wr_reg, bus.fwd_valid, bus.misalign});
    end
    vec_cnt++;
    if (bus.reg_din !== 32'h0 || bus.reg_addr !== 4'h0 || bus.fwd_data !== 32'h0 || bus.fwd_addr !== 4'h0) begin
      err_cnt++; $display("FAIL reset_data: got din=%h addr=%h required 0", bus.reg_din, bus.reg_addr);
    end
    vec_cnt++;
    if (bus.in_ready !== 1'b1 || bus.retired_count !== 16'd0) begin
      err_cnt++; $display("FAIL reset_ready_count: got rdy=%b cnt=%0d required 1/0", bus.in_ready, bus.retired_count);
    end
  endtask

  task automatic test_alu();
    drive(1'b1, REG_IN_ALU, 4'd5, 1'b1, LD_WORD, 1'b0, 2'd0, 32'h12345678);
    vec_cnt++;
    if (bus.in_ready !== 1'b1) begin
      err_cnt++; $display("FAIL alu_in_ready: got %b required 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    #1;
    vec_cnt++;
    if (bus.wr_reg !== 1'b1 || bus.reg_addr !== 4'd5 || bus.reg_din !== 32'h12345678) begin
      err_cnt++; $display("FAIL alu_write: got wr=%b addr=%0d din=%h required 1/5/12345678", bus.wr_reg, bus.reg_addr, bus.reg_din);
    end
    vec_cnt++;
    if (bus.fwd_valid !== 1'b1 || bus.fwd_addr !== 4'd5 || bus.fwd_data !== 32'h12345678) begin
      err_cnt++; $display("FAIL alu_fwd: got v=%b addr=%0d data=%h required 1/5/12345678", bus.fwd_valid, bus.fwd_addr, bus.fwd_data);
    end
    step();
    vec_cnt++;
    if (bus.retired_count !== 16'd1 || bus.wr_reg !== 1'b0 || bus.reg_din !== 32'h12345678) begin
      err_cnt++; $display("FAIL alu_commit: got cnt=%0d wr=%b din=%h required 1/0/12345678", bus.retired_count, bus.wr_reg, bus.reg_din);
    end
  endtask

  // Loads of 0x80FF7F01 with hand-computed aligned results; count starts at 1.
  task automatic test_loads();
    logic [1:0]  size_t [4] = '{LD_BYTE, LD_BYTE, LD_HALF, LD_WORD};
    logic        sgn_t  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0]  off_t  [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
    logic [31:0] exp_t  [4] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h80FF7F01};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, REG_IN_DOUT, 4'd9, 1'b1, size_t[i], sgn_t[i], off_t[i], 32'h80FF7F01);
      step();
      bus.in_valid = 1'b0;
      #1;
      vec_cnt++;
      if (bus.reg_din !== exp_t[i] || bus.wr_reg !== 1'b1 || bus.misalign !== 1'b0) begin
        err_cnt++; $display("FAIL load_%0d: got din=%h wr=%b mis=%b required %h/1/0", i, bus.reg_din, bus.wr_reg, bus.misalign, exp_t[i]);
      end
      step();
      vec_cnt++;
      if (bus.retired_count !== 16'(2 + i)) begin
        err_cnt++; $display("FAIL load_count_%0d: got %0d required %0d", i, bus.retired_count, 2 + i);
      end
    end
  endtask

  task automatic test_misalign();
    drive(1'b1, REG_IN_DOUT, 4'd6, 1'b1, LD_HALF, 1'b0, 2'd1, 32'h80FF7F01);
    step();
    bus.in_valid = 1'b0;
    #1;
    vec_cnt++;
    if (bus.misalign !== 1'b1 || bus.wr_reg !== 1'b0 || bus.fwd_valid !== 1'b0) begin
      err_cnt++; $display("FAIL misalign_half: got mis=%b wr=%b fwd=%b required 1/0/0", bus.misalign, bus.wr_reg, bus.fwd_valid);
    end
    step();
    vec_cnt++;
    if (bus.retired_count !== 16'd6 || bus.misalign !== 1'b0) begin
      err_cnt++; $display("FAIL misalign_count: got cnt=%0d mis=%b required 6/0", bus.retired_count, bus.misalign);
    end
    // Misaligned word but no register write: never flagged.
    drive(1'b1, REG_IN_DOUT, 4'd6, 1'b0, LD_WORD, 1'b0, 2'd2, 32'h80FF7F01);
    step();
    bus.in_valid = 1'b0;
    #1;
    vec_cnt++;
    if (bus.misalign !== 1'b0 || bus.wr_reg !== 1'b0) begin
      err_cnt++; $display("FAIL misalign_nowr: got mis=%b wr=%b required 0/0", bus.misalign, bus.wr_reg);
    end
    step();
    vec_cnt++;
    if (bus.retired_count !== 16'd7) begin
      err_cnt++; $display("FAIL nowr_count: got %0d required 7", bus.retired_count);
    end
  endtask

  task automatic test_stall();
    bus.rf_ready = 1'b0;
    drive(1'b1, REG_IN_ALU, 4'd1, 1'b1, LD_WORD, 1'b0, 2'd0, 32'hAAAA0001);
    step();
    drive(1'b1, REG_IN_ALU, 4'd2, 1'b1, LD_WORD, 1'b0, 2'd0, 32'hBBBB0002);
    for (int i = 0; i < 2; i++) begin
      #1;
      vec_cnt++;
      if (bus.in_ready !== 1'b0 || bus.wr_reg !== 1'b1 || bus.reg_addr !== 4'd1 ||
          bus.reg_din !== 32'hAAAA0001 || bus.retired_count !== 16'd7) begin
        err_cnt++; $display("FAIL stall_hold_%0d: got rdy=%b wr=%b addr=%0d din=%h cnt=%0d required 0/1/1/aaaa0001/7",
                            i, bus.in_ready, bus.wr_reg, bus.reg_addr, bus.reg_din, bus.retired_count);
      end
      step();
    end
    bus.rf_ready = 1'b1;
    #1;
    vec_cnt++;
    if (bus.in_ready !== 1'b1) begin
      err_cnt++; $display("FAIL stall_release_ready: got %b required 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    #1;
    vec_cnt++;
    if (bus.retired_count !== 16'd8 || bus.reg_addr !== 4'd2 || bus.reg_din !== 32'hBBBB0002 || bus.wr_reg !== 1'b1) begin
      err_cnt++; $display("FAIL stall_second: got cnt=%0d addr=%0d din=%h wr=%b required 8/2/bbbb0002/1",
                          bus.retired_count, bus.reg_addr, bus.reg_din, bus.wr_reg);
    end
    step();
    vec_cnt++;
    if (bus.retired_count !== 16'd9 || bus.wr_reg !== 1'b0) begin
      err_cnt++; $display("FAIL stall_drain: got cnt=%0d wr=%b required 9/0", bus.retired_count, bus.wr_reg);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, REG_IN_ALU, 4'd3, 1'b1, LD_WORD, 1'b0, 2'd0, 32'hCCCC0003);
    step();
    drive(1'b1, REG_IN_ALU, 4'd4, 1'b1, LD_WORD, 1'b0, 2'd0, 32'hDDDD0004);
    bus.flush = 1'b1;
    #1;
    vec_cnt++;
    if (bus.wr_reg !== 1'b0 || bus.fwd_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      err_cnt++; $display("FAIL flush_gate: got wr=%b fwd=%b rdy=%b required 0/0/0", bus.wr_reg, bus.fwd_valid, bus.in_ready);
    end
    step();
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    vec_cnt++;
    if (bus.retired_count !== 16'd9 || bus.wr_reg !== 1'b0 || bus.reg_din !== 32'hCCCC0003) begin
      err_cnt++; $display("FAIL flush_drop: got cnt=%0d wr=%b din=%h required 9/0/cccc0003", bus.retired_count, bus.wr_reg, bus.reg_din);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, REG_IN_PC4, 4'd7, 1'b1, LD_WORD, 1'b0, 2'd0, 32'hFFFFFFFC);
    step();
    drive(1'b1, REG_IN_IMM16, 4'd8, 1'b1, LD_WORD, 1'b0, 2'd0, 32'h0000BEEF);
    #1;
    vec_cnt++;
    if (bus.reg_din !== 32'h00000000 || bus.wr_reg !== 1'b1 || bus.reg_addr !== 4'd7) begin
      err_cnt++; $display("FAIL pc4_wrap: got din=%h wr=%b addr=%0d required 00000000/1/7", bus.reg_din, bus.wr_reg, bus.reg_addr);
    end
    step();
    drive(1'b1, REG_IN_PC4, 4'd10, 1'b1, LD_WORD, 1'b0, 2'd0, 32'h00000100);
    #1;
    vec_cnt++;
    if (bus.reg_din !== 32'h0000BEEF || bus.reg_addr !== 4'd8 || bus.retired_count !== 16'd10) begin
      err_cnt++; $display("FAIL b2b_imm: got din=%h addr=%0d cnt=%0d required 0000beef/8/10", bus.reg_din, bus.reg_addr, bus.retired_count);
    end
    step();
    bus.in_valid = 1'b0;
    #1;
    vec_cnt++;
    if (bus.reg_din !== 32'h00000104 || bus.retired_count !== 16'd11) begin
      err_cnt++; $display("FAIL b2b_pc4: got din=%h cnt=%0d required 00000104/11", bus.reg_din, bus.retired_count);
    end
    step();
    vec_cnt++;
    if (bus.retired_count !== 16'd12 || bus.wr_reg !== 1'b0) begin
      err_cnt++; $display("FAIL b2b_drain: got cnt=%0d wr=%b required 12/0", bus.retired_count, bus.wr_reg);
    end
  endtask

  task automatic test_reset_mid_stall();
    bus.rf_ready = 1'b0;
    drive(1'b1, REG_IN_ALU, 4'd11, 1'b1, LD_WORD, 1'b0, 2'd0, 32'hEEEE0005);
    step();
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    vec_cnt++;
    if (bus.wr_reg !== 1'b0 || bus.retired_count !== 16'd0 || bus.in_ready !== 1'b1 || bus.reg_din !== 32'h0) begin
      err_cnt++; $display("FAIL async_reset: got wr=%b cnt=%0d rdy=%b din=%h required 0/0/1/0",
                          bus.wr_reg, bus.retired_count, bus.in_ready, bus.reg_din);
    end
    step();
    reset = 1'b1;
    bus.rf_ready = 1'b1;
    step();
    vec_cnt++;
    if (bus.wr_reg !== 1'b0 || bus.retired_count !== 16'd0) begin
      err_cnt++; $display("FAIL post_reset_idle: got wr=%b cnt=%0d required 0/0", bus.wr_reg, bus.retired_count);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_alu();
    test_loads();
    test_misalign();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
